// File: rtl/div_unit.sv
// div_unit: iterative 32-bit integer divider (DIV, DIVU, REM, REMU).
// Restoring division, one quotient bit per clock. Divide-by-zero and
// signed overflow are resolved at accept time and skip the iteration phase.
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] D
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [4:0]      LastIter = 5'd31;
  localparam logic [XLEN-1:0] AllOnes  = '1;
  localparam logic [XLEN-1:0] MinInt   = {1'b1, {(XLEN-1){1'b0}}};

  state_t          r_state;
  logic [4:0]      r_cnt;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_div;
  logic            r_negQ;
  logic            r_negR;
  logic            r_isRem;
  logic            r_busy;
  logic            r_done;
  logic [XLEN-1:0] r_d;

  // op[0] selects unsigned, op[1] selects remainder
  logic            w_signed;
  logic            w_isRem;
  logic [XLEN-1:0] w_magA;
  logic [XLEN-1:0] w_magB;
  logic            w_divZero;
  logic            w_ovf;

  assign w_signed  = ~op[0];
  assign w_isRem   = op[1];
  assign w_magA    = (w_signed && A[XLEN-1]) ? (~A + 1'b1) : A;
  assign w_magB    = (w_signed && B[XLEN-1]) ? (~B + 1'b1) : B;
  assign w_divZero = (B == '0);
  assign w_ovf     = w_signed && (A == MinInt) && (B == AllOnes);

  // One restoring step: the 33-bit partial remainder is the previous
  // remainder shifted left with the next dividend bit; a clear borrow
  // bit in the trial difference means the divisor fits.
  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_diff;
  logic            w_fits;
  logic [XLEN-1:0] w_remNext;
  logic [XLEN-1:0] w_quoNext;
  logic [XLEN-1:0] w_result;

  assign w_shift   = {r_rem, r_quo[XLEN-1]};
  assign w_diff    = w_shift - {1'b0, r_div};
  assign w_fits    = ~w_diff[XLEN];
  assign w_remNext = w_fits ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
  assign w_quoNext = {r_quo[XLEN-2:0], w_fits};
  assign w_result  = r_isRem ? (r_negR ? (~w_remNext + 1'b1) : w_remNext)
                             : (r_negQ ? (~w_quoNext + 1'b1) : w_quoNext);

  // Control FSM and datapath: accept requests, iterate, publish result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_div   <= '0;
      r_negQ  <= 1'b0;
      r_negR  <= 1'b0;
      r_isRem <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_d     <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
          if (start) begin
            if (w_divZero) begin
              r_d     <= w_isRem ? A : AllOnes;
              r_done  <= 1'b1;
              r_state <= DONE;
            end else if (w_ovf) begin
              r_d     <= w_isRem ? '0 : MinInt;
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_rem   <= '0;
              r_quo   <= w_magA;
              r_div   <= w_magB;
              r_negQ  <= w_signed & (A[XLEN-1] ^ B[XLEN-1]);
              r_negR  <= w_signed & A[XLEN-1];
              r_isRem <= w_isRem;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          r_rem <= w_remNext;
          r_quo <= w_quoNext;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == LastIter) begin
            r_d     <= w_result;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign D    = r_d;

endmodule
